// File: rtl/tuple_enqueue_gen.sv
// tuple_enqueue_gen: write-side producer for the tuple/length FIFO that feeds
// the output queue. On start it latches a run configuration and writes
// cfg_pkt_count descriptors {five_tuple, pkt_len} into the FIFO, one per
// cycle, pausing while the FIFO reports nearly-full.
//
// Ports:
//   clk, resetn          single clock, async active-low reset
//   start, abort         one-cycle control pulses
//   cfg_*                run configuration, sampled only on an accepted start
//   fifo_data_in/wr_en   registered FIFO write port
//   fifo_nearly_full     back-pressure, one-cycle sample-to-strobe latency
//   busy, done           busy in RUN, done pulses once per run
//   sent_count           descriptors written since the last start
module tuple_enqueue_gen #(
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [PKT_TUPLE_WIDTH-1:0]             cfg_base_tuple,
  input  logic [15:0]                            cfg_sport_step,
  input  logic [CNT_WIDTH-1:0]                   cfg_pkt_count,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_min,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_max,
  input  logic [PKT_LEN_WIDTH-1:0]               cfg_len_step,
  output logic [PKT_TUPLE_WIDTH+PKT_LEN_WIDTH-1:0] fifo_data_in,
  output logic                                   fifo_wr_en,
  input  logic                                   fifo_nearly_full,
  output logic                                   busy,
  output logic                                   done,
  output logic [CNT_WIDTH-1:0]                   sent_count
);

  // sport sits above dport[15:0] and proto[7:0] in the tuple
  localparam int SPORT_LSB = 24;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [PKT_TUPLE_WIDTH-1:0] cur_tuple, tuple_adv;
  logic [PKT_LEN_WIDTH-1:0]   cur_len, len_adv;
  logic [PKT_LEN_WIDTH-1:0]   len_min, len_max, len_step;
  logic [15:0]                sport_step;
  logic [CNT_WIDTH-1:0]       remaining;
  logic [PKT_LEN_WIDTH:0]     len_sum;
  logic                       accept, fire;

  assign accept = (state == S_IDLE) && start;
  // abort has priority over a pending write so no strobe follows it
  assign fire   = (state == S_RUN) && !abort && !fifo_nearly_full &&
                  (remaining != '0);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Generator advance. The sum is one bit wider so a step that overflows the
  // length field still compares as "past max" and wraps to len_min. With
  // len_min > len_max every advance lands back on len_min.
  assign len_sum = {1'b0, cur_len} + {1'b0, len_step};

  always_comb begin
    tuple_adv = cur_tuple;
    tuple_adv[SPORT_LSB +: 16] = cur_tuple[SPORT_LSB +: 16] + sport_step;
    len_adv = (len_sum > {1'b0, len_max}) ? len_min
                                          : len_sum[PKT_LEN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (cfg_pkt_count == '0) ? S_DONE : S_RUN;
      S_RUN:  if (abort || remaining == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      sent_count   <= '0;
      cur_tuple    <= '0;
      cur_len      <= '0;
      remaining    <= '0;
      len_min      <= '0;
      len_max      <= '0;
      len_step     <= '0;
      sport_step   <= '0;
    end else begin
      fifo_wr_en <= fire;
      if (accept) begin
        cur_tuple  <= cfg_base_tuple;
        cur_len    <= cfg_len_min;
        remaining  <= cfg_pkt_count;
        sent_count <= '0;
        len_min    <= cfg_len_min;
        len_max    <= cfg_len_max;
        len_step   <= cfg_len_step;
        sport_step <= cfg_sport_step;
      end else if (fire) begin
        fifo_data_in <= {cur_tuple, cur_len};
        remaining    <= remaining - CNT_WIDTH'(1);
        sent_count   <= sent_count + CNT_WIDTH'(1);
        cur_tuple    <= tuple_adv;
        cur_len      <= len_adv;
      end
    end
  end

endmodule

// File: tb/tb_tuple_enqueue_gen.sv
module tb_tuple_enqueue_gen;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, abort;
  logic [103:0] cfg_base_tuple;
  logic [15:0]  cfg_sport_step;
  logic [31:0]  cfg_pkt_count;
  logic [15:0]  cfg_len_min, cfg_len_max, cfg_len_step;
  logic [119:0] fifo_data_in;
  logic         fifo_wr_en;
  logic         fifo_nearly_full;
  logic         busy, done;
  logic [31:0]  sent_count;

  always #5 clk = ~clk;

  tuple_enqueue_gen dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_base_tuple(cfg_base_tuple), .cfg_sport_step(cfg_sport_step),
    .cfg_pkt_count(cfg_pkt_count), .cfg_len_min(cfg_len_min),
    .cfg_len_max(cfg_len_max), .cfg_len_step(cfg_len_step),
    .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_nearly_full(fifo_nearly_full), .busy(busy), .done(done),
    .sent_count(sent_count)
  );

  typedef struct {
    logic [103:0] tuple;
    logic [15:0]  sstep;
    int           count;
    logic [15:0]  lmin, lmax, lstep;
  } cfg_t;

  typedef struct {
    cfg_t            c;
    int              n;
    logic [3:0][15:0] sp;
    logic [3:0][15:0] ln;
  } vec_t;

  int checks = 0, failures = 0;
  logic [119:0] got_q[$], exp_q[$];
  int wr_cyc[$];
  int done_cnt, done_cyc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic cfg_t mk(input logic [103:0] t, input logic [15:0] ss, input int n,
                              input logic [15:0] lmin, input logic [15:0] lmax,
                              input logic [15:0] lstep);
    cfg_t c;
    c.tuple = t; c.sstep = ss; c.count = n;
    c.lmin = lmin; c.lmax = lmax; c.lstep = lstep;
    return c;
  endfunction

  // Reference: descriptor i has sport = base + i*step (mod 2^16) and a length
  // that cycles through lmin, lmin+step, ... up to the last value <= lmax.
  task automatic model(input cfg_t c, input int n);
    logic [103:0] t;
    int len, per;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      t = c.tuple;
      t[39:24] = 16'((int'(c.tuple[39:24]) + i * int'(c.sstep)) % 65536);
      if (c.lmin > c.lmax || c.lstep == 0) len = int'(c.lmin);
      else begin
        per = (int'(c.lmax) - int'(c.lmin)) / int'(c.lstep) + 1;
        len = int'(c.lmin) + (i % per) * int'(c.lstep);
      end
      exp_q.push_back({t, 16'(len)});
    end
  endtask

  task automatic scramble();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_base_tuple = r[103:0];
    cfg_sport_step = 16'($urandom());
    cfg_pkt_count  = $urandom_range(1, 50);
    cfg_len_min    = 16'($urandom());
    cfg_len_max    = 16'($urandom());
    cfg_len_step   = 16'($urandom());
  endtask

  // Start a run, then sample at each falling edge and drive the next cycle's
  // inputs. Stops 4 cycles after the first done pulse or after a fixed budget.
  task automatic run(input cfg_t c, input int nf_pct, input int abort_at,
                     input int bp_after, input int bp_len, input bit abort_with_start);
    int bp_left, post;
    bit nf_prev, aborted, bp_used;
    got_q.delete(); wr_cyc.delete(); done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    cfg_base_tuple = c.tuple; cfg_sport_step = c.sstep; cfg_pkt_count = c.count;
    cfg_len_min = c.lmin; cfg_len_max = c.lmax; cfg_len_step = c.lstep;
    start = 1'b1; abort = abort_with_start; fifo_nearly_full = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    scramble();
    nf_prev = 0; aborted = 0; bp_used = 0; bp_left = 0; post = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (nf_prev) chk("nf_lag", fifo_wr_en, 0);
      if (fifo_wr_en) begin
        got_q.push_back(fifo_data_in);
        wr_cyc.push_back(cyc);
        chk("busy_on_write", busy, 1);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("busy_in_done", busy, 0);
      end
      if (done_cnt > 0) post++;
      if (post > 4) break;
      fifo_nearly_full = 1'b0; abort = 1'b0; start = 1'b0;
      if (bp_after >= 0 && !bp_used && got_q.size() == bp_after) begin
        bp_used = 1; bp_left = bp_len;
      end
      if (bp_left > 0) begin
        fifo_nearly_full = 1'b1; bp_left--;
      end else if (nf_pct > 0) fifo_nearly_full = ($urandom_range(99) < nf_pct);
      if (abort_at >= 0 && !aborted && got_q.size() == abort_at) begin
        abort = 1'b1; aborted = 1;
      end
      if (cyc == 3 && busy) start = 1'b1;
      nf_prev = fifo_nearly_full;
      @(negedge clk);
    end
    fifo_nearly_full = 1'b0; abort = 1'b0; start = 1'b0;
  endtask

  task automatic cmp_run(input string nm, input cfg_t c, input int n);
    model(c, n);
    chk({nm, "_nwrites"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({nm, "_word"}, got_q[i], exp_q[i]);
    chk({nm, "_sent"}, sent_count, n);
    chk({nm, "_done_pulses"}, done_cnt, 1);
  endtask

  vec_t tbl[6];
  cfg_t c;
  logic [103:0] base;

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; fifo_nearly_full = 1'b0;
    cfg_base_tuple = '0; cfg_sport_step = '0; cfg_pkt_count = '0;
    cfg_len_min = '0; cfg_len_max = '0; cfg_len_step = '0;
    base = {32'h0A000001, 32'h0A000002, 16'h1000, 16'h0050, 8'h11};

    tbl[0].c = mk(base, 16'd1, 4, 16'd64, 16'd64, 16'd1); tbl[0].n = 4;
    tbl[0].sp = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    tbl[0].ln = {16'd64, 16'd64, 16'd64, 16'd64};
    tbl[1].c = mk(base, 16'd1, 4, 16'd60, 16'd70, 16'd5); tbl[1].n = 4;
    tbl[1].sp = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    tbl[1].ln = {16'd60, 16'd70, 16'd65, 16'd60};
    tbl[2].c = mk({base[103:40], 16'hFFFE, base[23:0]}, 16'd1, 3, 16'd64, 16'd64, 16'd0);
    tbl[2].n = 3;
    tbl[2].sp = {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE};
    tbl[2].ln = {16'd0, 16'd64, 16'd64, 16'd64};
    tbl[3].c = mk(base, 16'd1, 0, 16'd64, 16'd64, 16'd1); tbl[3].n = 0;
    tbl[3].sp = '0; tbl[3].ln = '0;
    tbl[4].c = mk(base, 16'd16, 3, 16'd100, 16'd50, 16'd7); tbl[4].n = 3;
    tbl[4].sp = {16'h0000, 16'h1020, 16'h1010, 16'h1000};
    tbl[4].ln = {16'd0, 16'd100, 16'd100, 16'd100};
    tbl[5].c = mk(base, 16'hFFFF, 2, 16'd80, 16'd90, 16'd0); tbl[5].n = 2;
    tbl[5].sp = {16'h0000, 16'h0000, 16'h0FFF, 16'h1000};
    tbl[5].ln = {16'd0, 16'd0, 16'd80, 16'd80};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_count, 0);
    resetn = 1'b1;

    // directed table, no back-pressure
    for (int k = 0; k < 6; k++) begin
      run(tbl[k].c, 0, -1, -1, 0, 0);
      chk("tbl_nwrites", got_q.size(), tbl[k].n);
      chk("tbl_sent", sent_count, tbl[k].n);
      chk("tbl_done_pulses", done_cnt, 1);
      for (int i = 0; i < tbl[k].n && i < got_q.size(); i++) begin
        chk("tbl_sport", got_q[i][55:40], tbl[k].sp[i]);
        chk("tbl_len", got_q[i][15:0], tbl[k].ln[i]);
        chk("tbl_fields", {got_q[i][119:56], got_q[i][39:16]},
            {tbl[k].c.tuple[103:40], tbl[k].c.tuple[23:0]});
      end
      if (tbl[k].n > 0 && wr_cyc.size() == tbl[k].n) begin
        chk("tbl_first_latency", wr_cyc[0], 1);
        chk("tbl_contiguous", wr_cyc[tbl[k].n-1] - wr_cyc[0], tbl[k].n - 1);
        chk("tbl_done_timing", done_cyc, wr_cyc[tbl[k].n-1] + 1);
      end else if (tbl[k].n == 0) chk("tbl_done_timing", done_cyc, 0);
    end

    // back-pressure: 3 cycles of nearly-full once write 2 is visible
    c = mk(base, 16'd1, 6, 16'd60, 16'd70, 16'd5);
    run(c, 0, -1, 2, 3, 0);
    cmp_run("bp", c, 6);
    if (wr_cyc.size() == 6) begin
      chk("bp_gap", wr_cyc[2] - wr_cyc[1] - 1, 3);
      chk("bp_span", wr_cyc[5] - wr_cyc[0], 8);
    end

    // abort after 3 of 10
    c = mk(base, 16'd1, 10, 16'd64, 16'd64, 16'd1);
    run(c, 0, 3, -1, 0, 0);
    cmp_run("abort", c, 3);

    // start and abort together in IDLE: start wins
    c = mk(base, 16'd3, 3, 16'd64, 16'd128, 16'd32);
    run(c, 0, -1, -1, 0, 1);
    cmp_run("start_abort", c, 3);

    // async reset while streaming
    @(negedge clk);
    cfg_base_tuple = base; cfg_sport_step = 16'd1; cfg_pkt_count = 32'd10;
    cfg_len_min = 16'd64; cfg_len_max = 16'd64; cfg_len_step = 16'd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_wr_en", fifo_wr_en, 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_wr_en", fifo_wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sent", sent_count, 0);
    chk("arst_data", fifo_data_in, 0);
    @(negedge clk); resetn = 1'b1;
    c = mk(base, 16'd1, 2, 16'd64, 16'd64, 16'd0);
    run(c, 0, -1, -1, 0, 0);
    cmp_run("post_rst", c, 2);

    // randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [127:0] rt;
      int ab, n;
      rt = {$urandom(), $urandom(), $urandom(), $urandom()};
      c.tuple = rt[103:0];
      c.sstep = 16'($urandom());
      c.count = $urandom_range(0, 25);
      c.lmin  = 16'($urandom_range(40, 100));
      c.lmax  = 16'($urandom_range(40, 120));
      c.lstep = 16'($urandom_range(0, 15));
      if ($urandom_range(3) == 0) begin
        c.lmin = 16'($urandom_range(16'hFF00, 16'hFFF0));
        c.lmax = 16'hFFF0;
        c.lstep = 16'($urandom());
      end
      ab = -1; n = c.count;
      if (c.count > 0 && $urandom_range(3) == 0) begin
        ab = $urandom_range(0, c.count - 1); n = ab;
      end
      run(c, 30, ab, -1, 0, 0);
      cmp_run("rand", c, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tuple_enqueue_gen.md
Name: tuple_enqueue_gen

Overview:
- Producer (write side) of the tuple/length info FIFO feeding the output queue.
- Generates a configured number of packet descriptors. Each descriptor is a 104-bit five-tuple plus a 16-bit packet length.
- Writes one descriptor per cycle into the FIFO and throttles on the FIFO nearly-full flag.
- Sits between the control/register plane and the output queue in the packet generator.

Parameters:
- PKT_TUPLE_WIDTH, 104, five-tuple width; layout MSB..LSB is {src_ip[31:0], dst_ip[31:0], sport[15:0], dport[15:0], proto[7:0]}.
- PKT_LEN_WIDTH, 16, packet length width; FIFO word is PKT_TUPLE_WIDTH+PKT_LEN_WIDTH bits.
- CNT_WIDTH, 32, packet count / sent counter width.

Ports:
- clk  in  1  clock; single clock domain.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins generation. Ignored while busy.
- abort  in  1  one-cycle pulse; stops generation.
- cfg_base_tuple  in  PKT_TUPLE_WIDTH  first five-tuple.
- cfg_sport_step  in  16  sport increment per packet.
- cfg_pkt_count  in  CNT_WIDTH  number of descriptors to write.
- cfg_len_min  in  PKT_LEN_WIDTH  first and minimum packet length.
- cfg_len_max  in  PKT_LEN_WIDTH  maximum packet length.
- cfg_len_step  in  PKT_LEN_WIDTH  length increment per packet.
- fifo_data_in  out  PKT_TUPLE_WIDTH+PKT_LEN_WIDTH  {tuple, len}, registered.
- fifo_wr_en  out  1  write strobe, registered.
- fifo_nearly_full  in  1  FIFO back-pressure.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at completion or abort.
- sent_count  out  CNT_WIDTH  descriptors written since the last start.

Behaviour:
- Reset values (asynchronous, resetn=0): state IDLE; fifo_wr_en=0; fifo_data_in=0; busy=0; done=0; sent_count=0; all internal registers 0.
- States: IDLE, RUN, DONE.
- IDLE, on start:
  - Latch all cfg_*.
  - Set cur_tuple=cfg_base_tuple, cur_len=cfg_len_min, remaining=cfg_pkt_count, sent_count=0.
  - Go to RUN, or to DONE if cfg_pkt_count==0 (no writes in that case).
- RUN, each cycle with fifo_nearly_full==0 and remaining!=0:
  - Next cycle: fifo_wr_en=1, fifo_data_in={cur_tuple,cur_len}.
  - Decrement remaining; increment sent_count.
  - Advance the generator.
- RUN, fifo_nearly_full==1: next cycle fifo_wr_en=0; generator, remaining and sent_count hold.
- Nearly-full latency: one cycle from sampling to the write strobe. The FIFO nearly-full threshold must leave at least 2 free entries.
- RUN with remaining==0 after the last write: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. sent_count holds until the next start.
- Generator advance:
  - sport = sport + sport_step, mod 2^16; other tuple fields unchanged.
  - len_next = cur_len + len_step, computed 17-bit. If len_next > len_max, cur_len = len_min; else cur_len = len_next[15:0].
  - If len_min > len_max, len is fixed at len_min. If len_step==0, len is fixed.
- busy=1 in RUN, including the cycle the last write strobe is emitted. busy=0 in IDLE and DONE.
- abort in RUN: no write strobe in the following cycle or after. Go to DONE (done pulses). sent_count reflects only completed writes.
- abort in IDLE or DONE: ignored.
- abort and start in the same cycle in IDLE: start wins.
- start during RUN or DONE: ignored; latched config unchanged.
- cfg_* changes mid-run: no effect.
- fifo_wr_en is never high for more than cfg_pkt_count cycles per run.
- resetn asserted mid-run: immediate return to reset values; a partially emitted write strobe is dropped; no done pulse.

Test Plan:
- Basic run: base tuple {0x0A000001,0x0A000002,0x1000,0x0050,0x11}, step=1, len 64..64, count=4, nearly_full=0 -> 4 consecutive wr_en cycles; sport 0x1000..0x1003; len=64 each; done pulses 1 cycle after the last write; sent_count=4.
- Length wrap: len_min=60, len_max=70, step=5, count=4 -> lengths 60, 65, 70, 60.
- Sport wrap: sport=0xFFFE, step=1, count=3 -> sport 0xFFFE, 0xFFFF, 0x0000.
- Back-pressure: count=6; nearly_full high for 3 cycles after write 2 -> wr_en low for exactly 3 cycles (1-cycle lag); descriptors continue in sequence without gaps; total writes=6.
- count=0 start -> no wr_en; done pulse the cycle after IDLE->DONE; sent_count=0. Abort after 3 of 10 writes -> no further wr_en; done pulse; sent_count=3.
- Async reset mid-run (resetn low between clock edges) -> wr_en, busy, sent_count go 0 immediately without a clock edge; a subsequent start with count=2 produces exactly 2 writes.
